// File: rtl/adder_result_buffer_if.sv
// Handshake bundle between the adder, the result buffer and the downstream consumer.
// The slave modport is the buffer side; the master modport is the surrounding logic.
interface adder_result_buffer_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
);
    logic                       Valid_in;
    logic                       Ready_out;
    logic [WIDTH-1:0]           Rez_in;
    logic                       Sel_in;
    logic                       Valid_out;
    logic                       Ready_in;
    logic [WIDTH-1:0]           Rez_out;
    logic                       Sel_out;
    logic                       Zero_out;
    logic [$clog2(DEPTH):0]     Count_out;

    modport slave (
        input  Valid_in, Rez_in, Sel_in, Ready_in,
        output Ready_out, Valid_out, Rez_out, Sel_out, Zero_out, Count_out
    );

    modport master (
        output Valid_in, Rez_in, Sel_in, Ready_in,
        input  Ready_out, Valid_out, Rez_out, Sel_out, Zero_out, Count_out
    );
endinterface

// File: rtl/adder_result_buffer.sv
// Show-ahead FIFO for adder results {Sel, Rez} with valid/ready on both sides.
// Optional ADDER_RESULT_BUF_STATS_EN adds a saturating push counter and a stall flag.
module adder_result_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                 Clk_in,
    input  logic                 Rst_in,
    adder_result_buffer_if.slave bus
`ifdef ADDER_RESULT_BUF_STATS_EN
    ,
    output logic [15:0]          Pushed_out,
    output logic [0:0]           Stall_out
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH:0]     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [WIDTH:0]     head;

    // Acceptance depends only on occupancy, so a full buffer refuses a push
    // even when the consumer drains an entry on the same edge.
    assign bus.Ready_out = (count != FULL_CNT);
    assign bus.Valid_out = (count != '0);
    assign push          = bus.Valid_in && bus.Ready_out;
    assign pop           = bus.Valid_out && bus.Ready_in;

    assign head          = mem[rd_ptr];
    assign bus.Rez_out   = head[WIDTH-1:0];
    assign bus.Sel_out   = head[WIDTH];
    assign bus.Zero_out  = (head[WIDTH-1:0] == '0);
    assign bus.Count_out = count;

    always_ff @(posedge Clk_in or posedge Rst_in) begin
        if (Rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.Sel_in, bus.Rez_in};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ADDER_RESULT_BUF_STATS_EN
    assign Stall_out = bus.Valid_out && !bus.Ready_in;

    always_ff @(posedge Clk_in or posedge Rst_in) begin
        if (Rst_in) begin
            Pushed_out <= '0;
        end else if (push && (Pushed_out != 16'hFFFF)) begin
            Pushed_out <= Pushed_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_result_buffer.sv
// Scenario bench for adder_result_buffer; expected entries queue up as they are driven
// and are popped and compared as the buffer presents them at its head.
module tb_adder_result_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_result_buffer_if #(.DEPTH(4), .WIDTH(9)) bus ();

`ifdef ADDER_RESULT_BUF_STATS_EN
    logic [15:0] pushed;
    logic [0:0]  stall;
`endif

    adder_result_buffer #(.DEPTH(4), .WIDTH(9)) dut (
        .Clk_in     (clk),
        .Rst_in     (rst),
        .bus        (bus)
`ifdef ADDER_RESULT_BUF_STATS_EN
        ,
        .Pushed_out (pushed),
        .Stall_out  (stall)
`endif
    );

    int total = 0;
    int bad   = 0;
    int push_total = 0;
    logic [9:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.Valid_in = 1'b0;
        bus.Ready_in = 1'b0;
        bus.Rez_in   = '0;
        bus.Sel_in   = 1'b0;
        rst = 1'b1;
        #2;
        total++; if (bus.Valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", bus.Valid_out); end
        total++; if (bus.Ready_out !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", bus.Ready_out); end
        total++; if (bus.Rez_out !== 9'h000) begin bad++; $display("FAIL rst_rez got=%h want=000", bus.Rez_out); end
        total++; if (bus.Sel_out !== 1'b0) begin bad++; $display("FAIL rst_sel got=%0b want=0", bus.Sel_out); end
        total++; if (bus.Zero_out !== 1'b1) begin bad++; $display("FAIL rst_zero got=%0b want=1", bus.Zero_out); end
        total++; if (bus.Count_out !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.Count_out); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        total++; if (bus.Valid_out !== 1'b0) begin bad++; $display("FAIL idle_valid got=%0b want=0", bus.Valid_out); end
        total++; if (bus.Count_out !== 3'd0) begin bad++; $display("FAIL idle_count got=%0d want=0", bus.Count_out); end
        total++; if (bus.Ready_out !== 1'b1) begin bad++; $display("FAIL idle_ready got=%0b want=1", bus.Ready_out); end
    endtask

    task automatic test_single();
        logic [9:0] exp;
        bus.Rez_in   = 9'h105;
        bus.Sel_in   = 1'b0;
        bus.Valid_in = 1'b1;
        bus.Ready_in = 1'b1;
        exp_q.push_back({1'b0, 9'h105});
        push_total++;
        #1;
        total++; if (bus.Valid_out !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%0b want=0", bus.Valid_out); end
        tick();
        bus.Valid_in = 1'b0;
        exp = exp_q.pop_front();
        total++; if (bus.Valid_out !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", bus.Valid_out); end
        total++; if (bus.Rez_out !== exp[8:0]) begin bad++; $display("FAIL single_rez got=%h want=%h", bus.Rez_out, exp[8:0]); end
        total++; if (bus.Sel_out !== exp[9]) begin bad++; $display("FAIL single_sel got=%0b want=%0b", bus.Sel_out, exp[9]); end
        total++; if (bus.Zero_out !== 1'b0) begin bad++; $display("FAIL single_zero got=%0b want=0", bus.Zero_out); end
        total++; if (bus.Count_out !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", bus.Count_out); end
        tick();
        total++; if (bus.Count_out !== 3'd0) begin bad++; $display("FAIL single_drained got=%0d want=0", bus.Count_out); end
        total++; if (bus.Valid_out !== 1'b0) begin bad++; $display("FAIL single_empty got=%0b want=0", bus.Valid_out); end
    endtask

    task automatic test_full();
        logic [9:0] exp;
        bit         exp_rdy;
        bit         do_push;
        bit         do_pop;
        int         n;
        bus.Ready_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.Rez_in   = 9'(i);
            bus.Sel_in   = i[0];
            bus.Valid_in = 1'b1;
            exp_q.push_back({i[0], 9'(i)});
            push_total++;
            tick();
        end
        bus.Valid_in = 1'b0;
        total++; if (bus.Count_out !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", bus.Count_out); end
        total++; if (bus.Ready_out !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", bus.Ready_out); end
        bus.Rez_in   = 9'h1FF;
        bus.Sel_in   = 1'b1;
        bus.Valid_in = 1'b1;
        tick();
        exp = exp_q[0];
        total++; if (bus.Count_out !== 3'd4) begin bad++; $display("FAIL full_refused got=%0d want=4", bus.Count_out); end
        total++; if (bus.Rez_out !== exp[8:0]) begin bad++; $display("FAIL full_head_stable got=%h want=%h", bus.Rez_out, exp[8:0]); end
        bus.Ready_in = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || bus.Valid_in) && n < 20) begin
            exp_rdy = (exp_q.size() != 4);
            total++; if (bus.Ready_out !== exp_rdy) begin bad++; $display("FAIL full_drain_ready got=%0b want=%0b", bus.Ready_out, exp_rdy); end
            do_pop  = (exp_q.size() != 0);
            do_push = bus.Valid_in && exp_rdy;
            if (do_pop) begin
                exp = exp_q.pop_front();
                total++; if (bus.Rez_out !== exp[8:0] || bus.Sel_out !== exp[9]) begin bad++; $display("FAIL full_drain_head got=%b_%h want=%b_%h", bus.Sel_out, bus.Rez_out, exp[9], exp[8:0]); end
            end
            if (do_push) begin
                exp_q.push_back({bus.Sel_in, bus.Rez_in});
                push_total++;
            end
            tick();
            if (do_push) bus.Valid_in = 1'b0;
            n++;
        end
        total++; if (n >= 20) begin bad++; $display("FAIL full_drain_timeout got=%0d want<20", n); end
        total++; if (bus.Count_out !== 3'd0) begin bad++; $display("FAIL full_end_count got=%0d want=0", bus.Count_out); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        int         n;
        bus.Ready_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.Rez_in   = 9'h0F0 + 9'(i);
            bus.Sel_in   = 1'b1;
            bus.Valid_in = 1'b1;
            exp_q.push_back({1'b1, 9'h0F0 + 9'(i)});
            push_total++;
            tick();
        end
        bus.Ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.Rez_in   = 9'(i);
            bus.Sel_in   = i[0];
            bus.Valid_in = 1'b1;
            total++; if (bus.Count_out !== 3'd2) begin bad++; $display("FAIL b2b_count cycle=%0d got=%0d want=2", i, bus.Count_out); end
            exp = exp_q.pop_front();
            total++; if (bus.Rez_out !== exp[8:0] || bus.Sel_out !== exp[9]) begin bad++; $display("FAIL b2b_head cycle=%0d got=%b_%h want=%b_%h", i, bus.Sel_out, bus.Rez_out, exp[9], exp[8:0]); end
            exp_q.push_back({i[0], 9'(i)});
            push_total++;
            tick();
        end
        bus.Valid_in = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            exp = exp_q.pop_front();
            total++; if (bus.Rez_out !== exp[8:0] || bus.Sel_out !== exp[9]) begin bad++; $display("FAIL b2b_drain got=%b_%h want=%b_%h", bus.Sel_out, bus.Rez_out, exp[9], exp[8:0]); end
            tick();
            n++;
        end
        total++; if (bus.Count_out !== 3'd0) begin bad++; $display("FAIL b2b_end_count got=%0d want=0", bus.Count_out); end
    endtask

    task automatic test_zero();
        logic [9:0] exp;
        bus.Ready_in = 1'b0;
        bus.Rez_in   = 9'h000;
        bus.Sel_in   = 1'b1;
        bus.Valid_in = 1'b1;
        exp_q.push_back({1'b1, 9'h000});
        push_total++;
        tick();
        bus.Rez_in   = 9'h100;
        bus.Sel_in   = 1'b0;
        exp_q.push_back({1'b0, 9'h100});
        push_total++;
        exp = exp_q[0];
        total++; if (bus.Zero_out !== 1'b1) begin bad++; $display("FAIL zero_flag got=%0b want=1", bus.Zero_out); end
        total++; if (bus.Sel_out !== exp[9]) begin bad++; $display("FAIL zero_sel got=%0b want=%0b", bus.Sel_out, exp[9]); end
        total++; if (bus.Rez_out !== exp[8:0]) begin bad++; $display("FAIL zero_rez got=%h want=%h", bus.Rez_out, exp[8:0]); end
        tick();
        bus.Valid_in = 1'b0;
        bus.Ready_in = 1'b1;
        void'(exp_q.pop_front());
        tick();
        exp = exp_q.pop_front();
        total++; if (bus.Rez_out !== exp[8:0]) begin bad++; $display("FAIL carry_rez got=%h want=%h", bus.Rez_out, exp[8:0]); end
        total++; if (bus.Zero_out !== 1'b0) begin bad++; $display("FAIL carry_zero got=%0b want=0", bus.Zero_out); end
        tick();
        total++; if (bus.Count_out !== 3'd0) begin bad++; $display("FAIL zero_end_count got=%0d want=0", bus.Count_out); end
        bus.Ready_in = 1'b0;
    endtask

`ifdef ADDER_RESULT_BUF_STATS_EN
    task automatic test_stats();
        bus.Ready_in = 1'b0;
        bus.Rez_in   = 9'h033;
        bus.Sel_in   = 1'b0;
        bus.Valid_in = 1'b1;
        exp_q.push_back({1'b0, 9'h033});
        push_total++;
        tick();
        bus.Valid_in = 1'b0;
        total++; if (pushed !== 16'(push_total)) begin bad++; $display("FAIL stats_pushed got=%0d want=%0d", pushed, push_total); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL stats_stall got=%0b want=1", stall); end
        bus.Ready_in = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL stats_nostall got=%0b want=0", stall); end
        tick();
        void'(exp_q.pop_front());
        bus.Ready_in = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        bus.Ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.Rez_in   = 9'h0A0 + 9'(i);
            bus.Sel_in   = 1'b0;
            bus.Valid_in = 1'b1;
            exp_q.push_back({1'b0, 9'h0A0 + 9'(i)});
            tick();
        end
        bus.Valid_in = 1'b0;
        total++; if (bus.Count_out !== 3'd3) begin bad++; $display("FAIL arst_pre_count got=%0d want=3", bus.Count_out); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.Valid_out !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b want=0", bus.Valid_out); end
        total++; if (bus.Count_out !== 3'd0) begin bad++; $display("FAIL arst_count got=%0d want=0", bus.Count_out); end
        total++; if (bus.Rez_out !== 9'h000) begin bad++; $display("FAIL arst_rez got=%h want=000", bus.Rez_out); end
        total++; if (bus.Ready_out !== 1'b1) begin bad++; $display("FAIL arst_ready got=%0b want=1", bus.Ready_out); end
`ifdef ADDER_RESULT_BUF_STATS_EN
        total++; if (pushed !== 16'd0) begin bad++; $display("FAIL arst_pushed got=%0d want=0", pushed); end
`endif
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++; if (bus.Valid_out !== 1'b0) begin bad++; $display("FAIL arst_after got=%0b want=0", bus.Valid_out); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_zero();
`ifdef ADDER_RESULT_BUF_STATS_EN
        test_stats();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adder_result_buffer.md
Name: adder_result_buffer

Overview:
- Downstream stage of the 8-bit add/subtract unit.
- Captures each 9-bit result, together with the operation select that produced it, into a small FIFO.
- Presents buffered results to the next consumer over a valid/ready handshake.
- Decouples the combinational adder from a consumer that can stall, and flags zero results at the head.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, >= 2
WIDTH, 9, result width; matches the adder result bus

Ports:
Clk_in  input  1  single clock; all state updates on rising edge
Rst_in  input  1  asynchronous, active-high reset
Rez_in  input  WIDTH  result from adder
Sel_in  input  1  operation that produced Rez_in (0 = add, 1 = subtract)
Valid_in  input  1  upstream asserts when Rez_in/Sel_in are valid
Ready_out  output  1  buffer can accept an entry this cycle
Rez_out  output  WIDTH  head-of-FIFO result
Sel_out  output  1  head-of-FIFO operation select
Zero_out  output  1  head result equals 0
Valid_out  output  1  head entry valid
Ready_in  input  1  downstream can accept head entry
Count_out  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset: one clock; Rst_in is asynchronous and active-high.
  - While Rst_in is high: read/write pointers = 0, occupancy = 0, all storage = 0.
  - Outputs during reset: Valid_out = 0, Ready_out = 1, Rez_out = 0, Sel_out = 0, Zero_out = 1, Count_out = 0.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Push: on a rising edge where Valid_in && Ready_out, write {Sel_in, Rez_in} at the write pointer and advance it.
- Pop: on a rising edge where Valid_out && Ready_in, advance the read pointer.
- Ready_out = (occupancy != DEPTH).
  - Depends only on registered state, never on Ready_in.
  - When full, a push is refused even if a pop occurs in the same cycle.
- Valid_out = (occupancy != 0), registered-state driven.
- Head outputs are show-ahead: Rez_out/Sel_out always reflect the entry at the read pointer.
  - Rez_out/Sel_out are stable while Valid_out && !Ready_in.
- Latency: a result pushed into an empty buffer appears on Valid_out/Rez_out one cycle after the push edge. No combinational path from Rez_in to Rez_out.
- Zero_out = (Rez_out == 0); combinational from head storage.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- Occupancy updates on each edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance
  - neither: unchanged
- Empty buffer: only a push is possible (Valid_out = 0 blocks pop). Ready_in is ignored.
- Full buffer: only a pop is possible. Valid_in is ignored and Rez_in is not sampled.
- The upstream must hold Rez_in/Sel_in/Valid_in stable until accepted; the buffer drops nothing.
- No arithmetic on data: all WIDTH bits are stored verbatim, including bit 8 (carry/borrow).

Optional Feature:
Macro ADDER_RESULT_BUF_STATS_EN.
- Defined:
  - Adds output Pushed_out [15:0], counting accepted pushes.
  - Reset value 0; increments on each push edge; saturates at 16'hFFFF (no wrap).
  - Adds output Stall_out [0:0], high during any cycle with Valid_out && !Ready_in (combinational).
- Not defined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then idle -> Valid_out = 0, Ready_out = 1, Count_out = 0, Zero_out = 1, Rez_out = 9'h000.
- Push Rez_in = 9'h105, Sel_in = 0, with Ready_in = 1 -> next cycle Valid_out = 1, Rez_out = 9'h105, Sel_out = 0, Zero_out = 0; popped on the following edge, Count_out returns to 0.
- Hold Ready_in = 0, push 9'h001, 9'h002, 9'h003, 9'h004 -> Count_out = 4, Ready_out = 0.
  - A fifth Valid_in with 9'h1FF is not accepted.
  - Then Ready_in = 1 -> outputs 001, 002, 003, 004 in order, and 9'h1FF is accepted once Ready_out rises.
- Occupancy 2 with simultaneous push and pop for 10 cycles (values 0..9) -> Count_out stays 2, order preserved across pointer wrap.
- Push 9'h000 with Sel_in = 1 -> Zero_out = 1, Sel_out = 1 at the head.
- Assert Rst_in asynchronously between edges with Count_out = 3 -> Valid_out, Count_out, Rez_out go to 0 before the next clock edge. With ADDER_RESULT_BUF_STATS_EN defined, Pushed_out also returns to 0.
